// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences an external 8-bit EN/CLR/OV counter through programmable count
//   runs. A start request latches mode, terminal count and prescale. The
//   counter is then cleared and its enable is paced through the prescaler
//   until the counter reaches the latched terminal value. One-shot runs end
//   with a done pulse. Periodic runs clear the counter and start again.
//
// Ports
//   clk, Reset              system clock, synchronous active-low reset
//   start, stop             run request (IDLE only) / abort (CLEAR, RUN)
//   mode, terminal, prescale run configuration, latched at start
//   counter_in, ov_in       value and overflow flag of the controlled counter
//   cnt_en, cnt_clr         counter EN / CLR
//   busy, done, tick        status: run active, one-shot complete, terminal event
//   periods                 terminal events since last start (wraps)
//   ov_err                  sticky: overflow seen while running
//
// state | meaning
// IDLE  | waiting for start; counter untouched
// CLEAR | counter cleared, prescaler reset
// RUN   | enable paced by prescaler until counter == terminal
// DONE  | one-shot complete, done pulse
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int PS_W  = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] terminal,
  input  logic [PS_W-1:0]  prescale,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             ov_in,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [WIDTH-1:0] periods,
  output logic             ov_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state;
  logic             mode_l;
  logic [WIDTH-1:0] term_l;
  logic [PS_W-1:0]  pre_l;
  logic [PS_W-1:0]  pre;

  logic in_run;
  logic at_term;
  logic pre_hit;

  assign in_run  = (state == RUN);
  assign at_term = (counter_in == term_l);
  assign pre_hit = (pre == pre_l);

  // Enable and tick must react to stop/ov_in within the same cycle, so they
  // are decoded combinationally from the registered state.
  assign cnt_en  = in_run && pre_hit && !at_term && !stop && !ov_in;
  assign tick    = in_run && at_term && !stop && !ov_in;
  assign cnt_clr = (state == CLEAR);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state   <= IDLE;
      mode_l  <= 1'b0;
      term_l  <= '0;
      pre_l   <= '0;
      pre     <= '0;
      periods <= '0;
      ov_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_l  <= mode;
            term_l  <= terminal;
            pre_l   <= prescale;
            periods <= '0;
            ov_err  <= 1'b0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          pre   <= '0;
          state <= stop ? IDLE : RUN;
        end
        RUN: begin
          pre <= pre_hit ? '0 : pre + 1'b1;
          // Overflow outranks stop, which outranks the terminal event.
          if (ov_in) begin
            ov_err <= 1'b1;
            state  <= IDLE;
          end else if (stop) begin
            state <= IDLE;
          end else if (at_term) begin
            periods <= periods + 1'b1;
            state   <= mode_l ? CLEAR : DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
